attack_check_arb: RTL and testbench

ATTACK_CHECK_ARB -- requirements
Module: attack_check_arb

---
 rtl/attack_check_arb_pkg.sv | 31 +++
 rtl/attack_check_arb_rr_arb2.sv | 33 +++
 rtl/attack_check_arb.sv | 158 +++++++++++++++
 tb/tb_attack_check_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/attack_check_arb_pkg.sv
// Shared types and constants for the attack-check arbiter.
// Holds the FSM states, the side codes and the per-request context.
package attack_check_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic WHITE_ATTACK = 1'b0;
    localparam logic BLACK_ATTACK = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 8;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned SQUARES         = 64;

    typedef struct packed {
        logic [SQUARES-1:0] mask;
        logic               side;
    } req_ctx_t;

    // True when any square of interest is attacked by the requested side.
    function automatic logic any_hit(input req_ctx_t ctx,
                                     input logic [SQUARES-1:0] white,
                                     input logic [SQUARES-1:0] black);
        return |(ctx.mask & ((ctx.side == BLACK_ATTACK) ? black : white));
    endfunction

endpackage

// File: rtl/attack_check_arb_rr_arb2.sv
// Two-input round-robin grant; the pointer names the requester favoured on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       grant_any_c,
    output logic       grant_idx_c
);

    logic ptr_q;

    // After a completion, favour the requester that was not just served.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (update) begin
            ptr_q <= ~served;
        end
    end

    always_comb begin
        grant_any_c = |req;
        grant_idx_c = 1'b0;
        if (req == 2'b11) begin
            grant_idx_c = ptr_q;
        end else if (req[1]) begin
            grant_idx_c = 1'b1;
        end
    end

endmodule

// File: rtl/attack_check_arb.sv
// Arbitrates two requesters onto a shared 64-square attack array and reports
// whether any square of interest is attacked, with a timeout on the array.
module attack_check_arb
    import attack_check_arb_pkg::*;
#(
    parameter int unsigned PIECE_WIDTH = 4,
    parameter int unsigned SIDE_WIDTH  = PIECE_WIDTH * 8,
    parameter int unsigned BOARD_WIDTH = SIDE_WIDTH * 8,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [BOARD_WIDTH-1:0] req0_board,
    input  logic [SQUARES-1:0]     req0_mask,
    input  logic                   req0_side,
    output logic                   req0_done,
    output logic                   req0_hit,
    output logic                   req0_err,
    input  logic                   req1_valid,
    input  logic [BOARD_WIDTH-1:0] req1_board,
    input  logic [SQUARES-1:0]     req1_mask,
    input  logic                   req1_side,
    output logic                   req1_done,
    output logic                   req1_hit,
    output logic                   req1_err,
    output logic [BOARD_WIDTH-1:0] board_out,
    output logic                   board_out_valid,
    input  logic [SQUARES-1:0]     attacked_white,
    input  logic [SQUARES-1:0]     attacked_black,
    input  logic                   attacked_valid
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_ctx_t           ctx_q, ctx_d;
    logic               gidx_q, gidx_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         hit_q, hit_d;
    logic [1:0]         err_q, err_d;
    logic [BOARD_WIDTH-1:0] board_d;
    logic               bov_d;
    logic               grant_any_c;
    logic               grant_idx_c;
    logic               arb_update_c;
    logic               timeout_c;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req         ({req1_valid, req0_valid}),
        .update      (arb_update_c),
        .served      (gidx_q),
        .grant_any_c (grant_any_c),
        .grant_idx_c (grant_idx_c)
    );

    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_any_c) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (attacked_valid || timeout_c) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of every registered output; a real array result beats the timeout.
    always_comb begin
        board_d      = board_out;
        bov_d        = 1'b0;
        done_d       = '0;
        hit_d        = hit_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        ctx_d        = ctx_q;
        gidx_d       = gidx_q;
        arb_update_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                board_d = '0;
                cnt_d   = '0;
                if (grant_any_c) begin
                    gidx_d = grant_idx_c;
                    bov_d  = 1'b1;
                    if (grant_idx_c) begin
                        board_d = req1_board;
                        ctx_d   = '{mask: req1_mask, side: req1_side};
                    end else begin
                        board_d = req0_board;
                        ctx_d   = '{mask: req0_mask, side: req0_side};
                    end
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT: begin
                if (attacked_valid) begin
                    done_d[gidx_q] = 1'b1;
                    hit_d[gidx_q]  = any_hit(ctx_q, attacked_white, attacked_black);
                    err_d[gidx_q]  = 1'b0;
                end else if (timeout_c) begin
                    done_d[gidx_q] = 1'b1;
                    hit_d[gidx_q]  = 1'b0;
                    err_d[gidx_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                board_d      = '0;
                cnt_d        = '0;
                arb_update_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q           <= '0;
            ctx_q           <= '0;
            gidx_q          <= 1'b0;
            done_q          <= '0;
            hit_q           <= '0;
            err_q           <= '0;
            board_out       <= '0;
            board_out_valid <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            ctx_q           <= ctx_d;
            gidx_q          <= gidx_d;
            done_q          <= done_d;
            hit_q           <= hit_d;
            err_q           <= err_d;
            board_out       <= board_d;
            board_out_valid <= bov_d;
        end
    end

    assign req0_done = done_q[0];
    assign req1_done = done_q[1];
    assign req0_hit  = hit_q[0];
    assign req1_hit  = hit_q[1];
    assign req0_err  = err_q[0];
    assign req1_err  = err_q[1];

endmodule

// File: tb/tb_attack_check_arb.sv
// Bench for attack_check_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, result and timeout.
module tb_attack_check_arb;

    localparam int unsigned BW = 256;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [BW-1:0] req0_board = '0, req1_board = '0;
    logic [63:0]   req0_mask = '0, req1_mask = '0;
    logic          req0_side = 1'b0, req1_side = 1'b0;
    logic          req0_done, req1_done, req0_hit, req1_hit, req0_err, req1_err;
    logic [BW-1:0] board_out;
    logic          board_out_valid;
    logic [63:0]   attacked_white = '0, attacked_black = '0;
    logic          attacked_valid = 1'b0;

    int checks = 0;
    int errors = 0;
    int favor  = 0;
    bit exp_hit [2];
    bit exp_err [2];

    attack_check_arb #(.PIECE_WIDTH(4), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_board      (req0_board),
        .req0_mask       (req0_mask),
        .req0_side       (req0_side),
        .req0_done       (req0_done),
        .req0_hit        (req0_hit),
        .req0_err        (req0_err),
        .req1_valid      (req1_valid),
        .req1_board      (req1_board),
        .req1_mask       (req1_mask),
        .req1_side       (req1_side),
        .req1_done       (req1_done),
        .req1_hit        (req1_hit),
        .req1_err        (req1_err),
        .board_out       (board_out),
        .board_out_valid (board_out_valid),
        .attacked_white  (attacked_white),
        .attacked_black  (attacked_black),
        .attacked_valid  (attacked_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic check_results(input string tag);
        check({tag, "_hit0"}, BW'(req0_hit), BW'(exp_hit[0]));
        check({tag, "_hit1"}, BW'(req1_hit), BW'(exp_hit[1]));
        check({tag, "_err0"}, BW'(req0_err), BW'(exp_err[0]));
        check({tag, "_err1"}, BW'(req1_err), BW'(exp_err[1]));
    endtask

    task automatic clear_model();
        favor = 0;
        exp_hit[0] = 1'b0; exp_hit[1] = 1'b0;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    endtask

    // One transaction: array result arrives d cycles after the issue cycle.
    task automatic txn(input int d, input bit drop);
        int            g;
        int            kd;
        int            exp_k;
        bit            in_time;
        bit            seen;
        bit            h;
        logic [BW-1:0] b;
        logic [63:0]   m;
        logic          s;
        g = (req0_valid && req1_valid) ? favor : (req0_valid ? 0 : 1);
        b = (g == 1) ? req1_board : req0_board;
        m = (g == 1) ? req1_mask : req0_mask;
        s = (g == 1) ? req1_side : req0_side;
        in_time = (d >= 1) && (d <= int'(TO));
        h = in_time && ((m & (s ? attacked_black : attacked_white)) != 64'd0);
        exp_k = in_time ? d + 1 : int'(TO) + 1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            if (board_out_valid) seen = 1'b1;
        end
        check("issue_seen", BW'(seen), BW'(1'b1));
        check("issue_board", board_out, b);
        kd = 0;
        for (int k = 1; k <= int'(TO) + 4 && kd == 0; k++) begin
            @(negedge clk);
            if (req0_done || req1_done) kd = k;
            if (k == 1) check("issue_one_cycle", BW'(board_out_valid), BW'(1'b0));
            if (kd == 0) check("board_held", board_out, b);
            attacked_valid = (k == d) && (kd == 0);
        end
        attacked_valid = 1'b0;
        exp_hit[g] = h;
        exp_err[g] = !in_time;
        check("done_latency", BW'(kd), BW'(exp_k));
        check("done_who", BW'({req1_done, req0_done}), BW'(2'b01 << g));
        check_results("resp");
        favor = 1 - g;
        if (drop) begin
            if (g == 1) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        @(negedge clk);
        check("idle_board_zero", board_out, '0);
        check("done_one_cycle", BW'({req1_done, req0_done}), '0);
        check_results("held");
    endtask

    initial begin
        clear_model();
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_done", BW'({req1_done, req0_done}), '0);
        check("rst_bov", BW'(board_out_valid), '0);
        check("rst_board", board_out, '0);
        check_results("rst");
        reset = 1'b1;
        @(negedge clk);

        // Single requester, hit on square 4 by white
        req0_board = rand_board(); req0_mask = 64'd1 << 4; req0_side = 1'b0;
        attacked_white = 64'd1 << 4; attacked_black = '0;
        req0_valid = 1'b1;
        txn(2, 1'b1);

        // Both requesters from reset, then continuous alternation
        reset = 1'b0; @(negedge clk); reset = 1'b1; clear_model();
        req0_board = rand_board(); req1_board = ~req0_board;
        req0_mask = {$urandom(), $urandom()}; req1_mask = {$urandom(), $urandom()};
        attacked_white = {$urandom(), $urandom()}; attacked_black = {$urandom(), $urandom()};
        req0_valid = 1'b1; req1_valid = 1'b1;
        txn(2, 1'b1);
        txn(2, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        txn(2, 1'b0);
        txn(3, 1'b0);
        txn(1, 1'b0);
        txn(TO, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);

        // Black attacker, only white attacks the masked squares
        req0_mask = (64'd1 << 60) | (64'd1 << 61); req0_side = 1'b1;
        attacked_white = (64'd1 << 60) | (64'd1 << 61); attacked_black = '0;
        req0_valid = 1'b1;
        txn(2, 1'b1);

        // Array never answers, then the pointer must favour req1
        req0_valid = 1'b1;
        txn(100, 1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        txn(2, 1'b1);
        txn(2, 1'b1);

        // Asynchronous reset while waiting on the array
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_bov", BW'(board_out_valid), '0);
        check("arst_board", board_out, '0);
        clear_model();
        check_results("arst");
        attacked_valid = 1'b1;
        @(negedge clk);
        attacked_valid = 1'b0;
        check("arst_no_done", BW'({req1_done, req0_done}), '0);
        reset = 1'b1;
        txn(2, 1'b1);
        txn(2, 1'b1);

        // Array strobe while idle does nothing
        for (int i = 0; i < 3; i++) begin
            attacked_valid = 1'b1;
            @(negedge clk);
            check("idle_strobe_done", BW'({req1_done, req0_done}), '0);
            check("idle_strobe_bov", BW'(board_out_valid), '0);
        end
        attacked_valid = 1'b0;
        @(negedge clk);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            if (!req0_valid) begin
                req0_board = rand_board();
                req0_mask  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
                req0_side  = 1'($urandom_range(0, 1));
                req0_valid = 1'($urandom_range(0, 1));
            end
            if (!req1_valid) begin
                req1_board = rand_board();
                req1_mask  = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
                req1_side  = 1'($urandom_range(0, 1));
                req1_valid = 1'($urandom_range(0, 1));
            end
            if (!req0_valid && !req1_valid) req0_valid = 1'b1;
            attacked_white = {$urandom(), $urandom()};
            attacked_black = {$urandom(), $urandom()};
            txn(int'($urandom_range(1, TO + 2)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
